ps2_ascii_tx_queue: RTL and testbench

Sits between the PS/2 keyboard receiver and the UART transmitter in the sender design. It takes raw scan-code-set-2 bytes (`keycode` with its one-cycle `key_valid` strobe) and decodes make/break/extended prefixes. Mapped key presses are converted to ASCII and buffered in a small FIFO. The block then drains the FIFO to the UART transmitter with a start/busy handshake, and exposes the last queued character for the seven-segment display.

---
 rtl/ps2_ascii_tx_queue.sv | 186 ++++++++++++++++++
 tb/tb_ps2_ascii_tx_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_tx_queue.sv
// Generic circular FIFO; power-of-two depth, pointers wrap naturally.
// Latency: write visible at head one cycle after push; registered occupancy.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle.
module fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    output logic          wr_rdy,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_vld  = (count != '0);
    assign do_pop  = rd_rdy && rd_vld;
    assign wr_rdy  = !full || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// PS/2 set-2 decoder, lowercase ASCII queue and UART drain for the sender.
// Latency: key -> count/last_ascii next cycle; tx_start two cycles after key when idle.
// Backpressure: tx_busy stalls the drain; pushes into a full FIFO are dropped, overflow sticks.
module ps2_ascii_tx_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        keycode,
    input  logic              key_valid,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [7:0]        last_ascii,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {D_IDLE, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ACK, T_BUSY} tx_state_t;

    dec_state_t dec_q, dec_nxt;
    tx_state_t  tx_q, tx_nxt;

    logic [8:0] key_map;
    logic       push_vld;
    logic       push_rdy;
    logic       head_vld;
    logic [7:0] head_dat;
    logic       pop;
    logic       tx_start_nxt;
    logic [7:0] tx_data_nxt;

    // {hit, ascii}; shift keys and anything unlisted miss.
    function automatic logic [8:0] map_key(input logic [7:0] code);
        case (code)
            8'h1C: map_key = {1'b1, 8'h61}; 8'h32: map_key = {1'b1, 8'h62};
            8'h21: map_key = {1'b1, 8'h63}; 8'h23: map_key = {1'b1, 8'h64};
            8'h24: map_key = {1'b1, 8'h65}; 8'h2B: map_key = {1'b1, 8'h66};
            8'h34: map_key = {1'b1, 8'h67}; 8'h33: map_key = {1'b1, 8'h68};
            8'h43: map_key = {1'b1, 8'h69}; 8'h3B: map_key = {1'b1, 8'h6A};
            8'h42: map_key = {1'b1, 8'h6B}; 8'h4B: map_key = {1'b1, 8'h6C};
            8'h3A: map_key = {1'b1, 8'h6D}; 8'h31: map_key = {1'b1, 8'h6E};
            8'h44: map_key = {1'b1, 8'h6F}; 8'h4D: map_key = {1'b1, 8'h70};
            8'h15: map_key = {1'b1, 8'h71}; 8'h2D: map_key = {1'b1, 8'h72};
            8'h1B: map_key = {1'b1, 8'h73}; 8'h2C: map_key = {1'b1, 8'h74};
            8'h3C: map_key = {1'b1, 8'h75}; 8'h2A: map_key = {1'b1, 8'h76};
            8'h1D: map_key = {1'b1, 8'h77}; 8'h22: map_key = {1'b1, 8'h78};
            8'h35: map_key = {1'b1, 8'h79}; 8'h1A: map_key = {1'b1, 8'h7A};
            8'h45: map_key = {1'b1, 8'h30}; 8'h16: map_key = {1'b1, 8'h31};
            8'h1E: map_key = {1'b1, 8'h32}; 8'h26: map_key = {1'b1, 8'h33};
            8'h25: map_key = {1'b1, 8'h34}; 8'h2E: map_key = {1'b1, 8'h35};
            8'h36: map_key = {1'b1, 8'h36}; 8'h3D: map_key = {1'b1, 8'h37};
            8'h3E: map_key = {1'b1, 8'h38}; 8'h46: map_key = {1'b1, 8'h39};
            8'h29: map_key = {1'b1, 8'h20}; 8'h5A: map_key = {1'b1, 8'h0D};
            8'h66: map_key = {1'b1, 8'h08};
            default: map_key = 9'h000;
        endcase
    endfunction

    assign key_map = map_key(keycode);

    always_comb begin
        dec_nxt  = dec_q;
        push_vld = 1'b0;
        if (key_valid) begin
            case (dec_q)
                D_IDLE: begin
                    if (keycode == CODE_BREAK)    dec_nxt = D_BREAK;
                    else if (keycode == CODE_EXT) dec_nxt = D_EXT;
                    else                          push_vld = key_map[8];
                end
                D_EXT:   dec_nxt = (keycode == CODE_BREAK) ? D_EXT_BREAK : D_IDLE;
                default: dec_nxt = D_IDLE;
            endcase
        end
    end

    fifo #(.DW(8), .DEPTH(DEPTH), .AW(ADDR_W)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_rdy (push_rdy),
        .wr_dat (key_map[7:0]),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head_dat),
        .count  (count)
    );

    // Pop is taken on the same edge that raises tx_start, so data and count move together.
    always_comb begin
        tx_nxt       = tx_q;
        pop          = 1'b0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        case (tx_q)
            T_IDLE: begin
                if (head_vld && !tx_busy) begin
                    pop          = 1'b1;
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = head_dat;
                    tx_nxt       = T_ACK;
                end
            end
            T_ACK:   if (tx_busy)  tx_nxt = T_BUSY;
            T_BUSY:  if (!tx_busy) tx_nxt = T_IDLE;
            default: tx_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q      <= D_IDLE;
            tx_q       <= T_IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            last_ascii <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            dec_q    <= dec_nxt;
            tx_q     <= tx_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            if (push_vld && push_rdy)  last_ascii <= key_map[7:0];
            if (push_vld && !push_rdy) overflow   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_ascii_tx_queue.sv
// Directed bench: scan-code table sweep plus hand-built queue/drain/reset sequences.
module tb_ps2_ascii_tx_queue;
    logic       clk;
    logic       rst_n;
    logic [7:0] keycode;
    logic       key_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] last_ascii;
    logic [3:0] count;
    logic       overflow;

    logic       hold_busy;
    int         model_cnt;
    int         starts;
    int         viol;
    logic       prev_start;
    logic [7:0] rx[$];

    int tests;
    int fails;

    typedef struct {
        logic [7:0] code;
        logic       mapped;
        logic [7:0] ascii;
    } vec_t;
    vec_t vecs[$];

    ps2_ascii_tx_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keycode    (keycode),
        .key_valid  (key_valid),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .last_ascii (last_ascii),
        .count      (count),
        .overflow   (overflow)
    );

    assign tx_busy = hold_busy | (model_cnt != 0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART model: busy for 10 cycles after each start pulse, records every byte.
    initial begin
        model_cnt  = 0;
        starts     = 0;
        viol       = 0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                rx.push_back(tx_data);
                starts++;
                model_cnt = 10;
                if (prev_start) viol++;
            end else if (model_cnt != 0) begin
                model_cnt--;
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] code, input logic mapped, input logic [7:0] ascii);
        vec_t v;
        v.code   = code;
        v.mapped = mapped;
        v.ascii  = ascii;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the next negedge (cycle N+1).
    task automatic send_key(input logic [7:0] code);
        keycode   = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_last_ascii"}, 32'(last_ascii), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_wait", 32'(rx.size() >= n), 1);
    endtask

    initial begin
        logic [7:0] letters [26];
        logic [7:0] digits  [10];
        logic [7:0] exp_last;
        logic [7:0] seq_ext [8];
        int         s0;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        keycode = 8'h00;
        key_valid = 1'b0;
        hold_busy = 1'b0;

        letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) add_vec(letters[i], 1'b1, 8'(8'h61 + i));
        for (int i = 0; i < 10; i++) add_vec(digits[i], 1'b1, 8'(8'h30 + i));
        add_vec(8'h29, 1'b1, 8'h20);
        add_vec(8'h5A, 1'b1, 8'h0D);
        add_vec(8'h66, 1'b1, 8'h08);
        add_vec(8'h12, 1'b0, 8'h00);
        add_vec(8'h59, 1'b0, 8'h00);
        add_vec(8'h00, 1'b0, 8'h00);
        add_vec(8'h76, 1'b0, 8'h00);
        add_vec(8'h0E, 1'b0, 8'h00);

        @(negedge clk);
        do_reset("rst0");

        // Table sweep: each byte alone from an idle queue and drain.
        exp_last = 8'h00;
        foreach (vecs[i]) begin
            send_key(vecs[i].code);
            if (vecs[i].mapped) exp_last = vecs[i].ascii;
            check($sformatf("count_n1_%02h", vecs[i].code), 32'(count), 32'(vecs[i].mapped));
            check($sformatf("last_n1_%02h", vecs[i].code), 32'(last_ascii), 32'(exp_last));
            @(negedge clk);
            check($sformatf("start_n2_%02h", vecs[i].code), 32'(tx_start), 32'(vecs[i].mapped));
            check($sformatf("count_n2_%02h", vecs[i].code), 32'(count), 0);
            if (vecs[i].mapped)
                check($sformatf("data_n2_%02h", vecs[i].code), 32'(tx_data), 32'(vecs[i].ascii));
            @(negedge clk);
            check($sformatf("start_n3_%02h", vecs[i].code), 32'(tx_start), 0);
            idle(13);
        end

        // Make then break of 'a' sends one byte; decoder is back in D_IDLE afterwards.
        rx.delete();
        send_key(8'h1C);
        send_key(8'hF0);
        send_key(8'h1C);
        idle(30);
        check("mkbrk_rx_size", 32'(rx.size()), 1);
        check("mkbrk_rx0", 32'(rx[0]), 32'h61);
        send_key(8'h1C);
        wait_rx(2, 40);
        check("mkbrk_rx1", 32'(rx[1]), 32'h61);
        idle(15);

        // Extended make/break is dropped; only '1' gets through, shifts drop.
        rx.delete();
        seq_ext = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16, 8'h12, 8'h59};
        for (int i = 0; i < 8; i++) send_key(seq_ext[i]);
        idle(40);
        check("ext_rx_size", 32'(rx.size()), 1);
        check("ext_rx0", 32'(rx[0]), 32'h31);
        check("ext_last", 32'(last_ascii), 32'h31);

        // Overflow: nine keys into a stalled queue, 'i' is lost.
        do_reset("rst1");
        rx.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) send_key(letters[i]);
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_last", 32'(last_ascii), 32'h68);
        hold_busy = 1'b0;
        wait_rx(8, 400);
        for (int i = 0; i < 8; i++) check($sformatf("ovf_rx%0d", i), 32'(rx[i]), 32'(8'h61 + i));
        idle(30);
        check("ovf_rx_size", 32'(rx.size()), 8);
        check("ovf_count_end", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Full queue: push lands in the exact cycle of a pop and is accepted.
        do_reset("rst2");
        rx.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 8; i++) send_key(letters[i]);
        check("fullpp_count_pre", 32'(count), 8);
        check("fullpp_ovf_pre", 32'(overflow), 0);
        hold_busy = 1'b0;
        send_key(8'h3B);
        check("fullpp_count", 32'(count), 8);
        check("fullpp_ovf", 32'(overflow), 0);
        check("fullpp_start", 32'(tx_start), 1);
        check("fullpp_data", 32'(tx_data), 32'h61);
        check("fullpp_last", 32'(last_ascii), 32'h6A);
        wait_rx(9, 400);
        for (int i = 0; i < 8; i++) check($sformatf("fullpp_rx%0d", i), 32'(rx[i]), 32'(8'h61 + i));
        check("fullpp_rx8", 32'(rx[8]), 32'h6A);
        idle(20);

        // Reset during T_BUSY with three still queued abandons everything.
        do_reset("rst3");
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_key(letters[i]);
        hold_busy = 1'b0;
        @(negedge clk);
        check("midrst_start", 32'(tx_start), 1);
        idle(3);
        check("midrst_count", 32'(count), 3);
        do_reset("rst4");
        s0 = starts;
        idle(40);
        check("midrst_no_start", 32'(starts - s0), 0);

        check("start_pulse_width", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
